// File: rtl/vm_write_arbiter.sv
// vm_write_arbiter: owns VM character RAM port A and shares it between
// CPU single-byte writes (req/ack, highest priority) and a fill engine
// that sweeps a wrapping address range with one character.
module vm_write_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 13
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [LEN_W-1:0]  fill_len,
    input  logic [DATA_W-1:0] fill_data,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              vm_we,
    output logic [ADDR_W-1:0] vm_addr,
    output logic [DATA_W-1:0] vm_din
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                vm_we_q, vm_we_d;
    logic [ADDR_W-1:0]   vm_addr_q, vm_addr_d;
    logic [DATA_W-1:0]   vm_din_q, vm_din_d;
    logic                wr_ack_q, wr_ack_d;
    logic                fill_busy_q, fill_busy_d;
    logic                fill_done_q, fill_done_d;
    logic                cpu_grant;

    // A registered ack blocks the cycle right after a grant, so a held
    // request is served at most once every two cycles.
    assign cpu_grant = wr_req && !wr_ack_q;

    // Next-state and next-output computation for the port A owner.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d     = state_q;
        cur_d       = cur_q;
        rem_d       = rem_q;
        data_d      = data_q;
        vm_we_d     = 1'b0;
        vm_addr_d   = vm_addr_q;
        vm_din_d    = vm_din_q;
        wr_ack_d    = 1'b0;
        fill_done_d = 1'b0;

        if (cpu_grant) begin
            vm_we_d   = 1'b1;
            vm_addr_d = wr_addr;
            vm_din_d  = wr_data;
            wr_ack_d  = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    if (fill_len != '0) begin
                        cur_d   = fill_base;
                        rem_d   = fill_len;
                        data_d  = fill_data;
                        state_d = FILL;
                    end else begin
                        fill_done_d = 1'b1;
                    end
                end
            end
            FILL: begin
                // CPU owns the port this cycle; the sweep holds its position.
                if (!cpu_grant) begin
                    vm_we_d   = 1'b1;
                    vm_addr_d = cur_q;
                    vm_din_d  = data_q;
                    cur_d     = cur_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d     = IDLE;
                        fill_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        fill_busy_d = (state_d == FILL);
    end

    // State and registered outputs; reset abandons any fill silently.
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            vm_we_q     <= 1'b0;
            vm_addr_q   <= '0;
            vm_din_q    <= '0;
            wr_ack_q    <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cur_q       <= cur_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            vm_we_q     <= vm_we_d;
            vm_addr_q   <= vm_addr_d;
            vm_din_q    <= vm_din_d;
            wr_ack_q    <= wr_ack_d;
            fill_busy_q <= fill_busy_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign vm_we     = vm_we_q;
    assign vm_addr   = vm_addr_q;
    assign vm_din    = vm_din_q;
    assign wr_ack    = wr_ack_q;
    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;

endmodule

// File: tb/tb_vm_write_arbiter.sv
// Directed bench for vm_write_arbiter: outputs are sampled on the falling
// edge, inputs are changed on the falling edge after sampling.
module tb_vm_write_arbiter;

    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        fill_start;
    logic [11:0] fill_base;
    logic [12:0] fill_len;
    logic [7:0]  fill_data;
    logic        fill_busy;
    logic        fill_done;
    logic        vm_we;
    logic [11:0] vm_addr;
    logic [7:0]  vm_din;

    int checks = 0;
    int errors = 0;

    vm_write_arbiter #(.ADDR_W(12), .DATA_W(8), .LEN_W(13)) dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .fill_start(fill_start),
        .fill_base (fill_base),
        .fill_len  (fill_len),
        .fill_data (fill_data),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .vm_we     (vm_we),
        .vm_addr   (vm_addr),
        .vm_din    (vm_din)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks all port A / status outputs in one go.
    task automatic expect_out(input string tag, input logic we, input logic [11:0] addr,
                              input logic [7:0] din, input logic ack,
                              input logic busy, input logic done);
        check({tag, ".we"},   32'(vm_we),     32'(we));
        if (we) begin
            check({tag, ".addr"}, 32'(vm_addr), 32'(addr));
            check({tag, ".din"},  32'(vm_din),  32'(din));
        end
        check({tag, ".ack"},  32'(wr_ack),    32'(ack));
        check({tag, ".busy"}, 32'(fill_busy), 32'(busy));
        check({tag, ".done"}, 32'(fill_done), 32'(done));
    endtask

    task automatic start_fill(input logic [11:0] base, input logic [12:0] len, input logic [7:0] data);
        fill_start = 1'b1;
        fill_base  = base;
        fill_len   = len;
        fill_data  = data;
    endtask

    initial begin
        rst        = 1'b1;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_data  = '0;

        // Reset state
        @(negedge clk_50mhz);
        @(negedge clk_50mhz);
        expect_out("reset", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        check("reset.addr", 32'(vm_addr), 32'h0);
        check("reset.din",  32'(vm_din),  32'h0);
        rst = 1'b0;
        @(negedge clk_50mhz);
        expect_out("idle", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Single CPU write, 1-cycle latency, one-cycle ack
        wr_req = 1'b1; wr_addr = 12'h005; wr_data = 8'h41;
        @(negedge clk_50mhz);
        expect_out("cpu1", 1'b1, 12'h005, 8'h41, 1'b1, 1'b0, 1'b0);
        wr_req = 1'b0;
        @(negedge clk_50mhz);
        expect_out("cpu1_after", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        check("cpu1_hold.addr", 32'(vm_addr), 32'h005);
        check("cpu1_hold.din",  32'(vm_din),  32'h41);

        // Held request: grants every second cycle
        wr_req = 1'b1; wr_addr = 12'h010; wr_data = 8'h55;
        @(negedge clk_50mhz);
        expect_out("held_g1", 1'b1, 12'h010, 8'h55, 1'b1, 1'b0, 1'b0);
        @(negedge clk_50mhz);
        expect_out("held_gap1", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_50mhz);
        expect_out("held_g2", 1'b1, 12'h010, 8'h55, 1'b1, 1'b0, 1'b0);
        @(negedge clk_50mhz);
        expect_out("held_gap2", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        wr_req = 1'b0;
        @(negedge clk_50mhz);
        expect_out("held_end", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Full clear: 1024 cells from 0 with 0x20
        start_fill(12'h000, 13'd1024, 8'h20);
        @(negedge clk_50mhz);
        expect_out("clr_enter", 1'b0, 12'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        fill_start = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk_50mhz);
            expect_out($sformatf("clr_%0d", i), 1'b1, 12'(i), 8'h20, 1'b0,
                       (i != 1023), (i == 1023));
        end
        @(negedge clk_50mhz);
        expect_out("clr_end", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Wrap past the top of the address space
        start_fill(12'hFFE, 13'd4, 8'h2A);
        @(negedge clk_50mhz);
        fill_start = 1'b0;
        expect_out("wrap_enter", 1'b0, 12'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("wrap_0", 1'b1, 12'hFFE, 8'h2A, 1'b0, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("wrap_1", 1'b1, 12'hFFF, 8'h2A, 1'b0, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("wrap_2", 1'b1, 12'h000, 8'h2A, 1'b0, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("wrap_3", 1'b1, 12'h001, 8'h2A, 1'b0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        expect_out("wrap_end", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Zero length: done only, no writes, never busy
        start_fill(12'h123, 13'd0, 8'h77);
        @(negedge clk_50mhz);
        fill_start = 1'b0;
        expect_out("len0", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        expect_out("len0_end", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // fill_start during FILL is ignored
        start_fill(12'h200, 13'd4, 8'h11);
        @(negedge clk_50mhz);
        expect_out("ign_enter", 1'b0, 12'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        start_fill(12'h300, 13'd2, 8'h22);
        @(negedge clk_50mhz);
        fill_start = 1'b0;
        expect_out("ign_0", 1'b1, 12'h200, 8'h11, 1'b0, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("ign_1", 1'b1, 12'h201, 8'h11, 1'b0, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("ign_2", 1'b1, 12'h202, 8'h11, 1'b0, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("ign_3", 1'b1, 12'h203, 8'h11, 1'b0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        expect_out("ign_end", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // fill_start together with a CPU grant in IDLE
        start_fill(12'h080, 13'd2, 8'h44);
        wr_req = 1'b1; wr_addr = 12'h0AA; wr_data = 8'h99;
        @(negedge clk_50mhz);
        fill_start = 1'b0;
        wr_req     = 1'b0;
        expect_out("both_cpu", 1'b1, 12'h0AA, 8'h99, 1'b1, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("both_f0", 1'b1, 12'h080, 8'h44, 1'b0, 1'b1, 1'b0);
        @(negedge clk_50mhz);
        expect_out("both_f1", 1'b1, 12'h081, 8'h44, 1'b0, 1'b0, 1'b1);
        @(negedge clk_50mhz);
        expect_out("both_end", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Contention: CPU held during a len=8 fill, alternating C,F,C,F...
        start_fill(12'h040, 13'd8, 8'h33);
        @(negedge clk_50mhz);
        fill_start = 1'b0;
        expect_out("cont_enter", 1'b0, 12'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        wr_req = 1'b1; wr_addr = 12'h100; wr_data = 8'h77;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_50mhz);
            if (k % 2 == 0)
                expect_out($sformatf("cont_cpu_%0d", k), 1'b1, 12'h100, 8'h77, 1'b1, 1'b1, 1'b0);
            else
                expect_out($sformatf("cont_fill_%0d", k), 1'b1, 12'(12'h040 + (k - 1) / 2), 8'h33,
                           1'b0, (k != 15), (k == 15));
        end
        wr_req = 1'b0;
        @(negedge clk_50mhz);
        expect_out("cont_end", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-fill abandons it with no fill_done
        start_fill(12'h000, 13'd10, 8'h55);
        @(negedge clk_50mhz);
        fill_start = 1'b0;
        @(negedge clk_50mhz);
        @(negedge clk_50mhz);
        expect_out("mid_pre", 1'b1, 12'h001, 8'h55, 1'b0, 1'b1, 1'b0);
        #3 rst = 1'b1;
        #1;
        expect_out("mid_rst", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        check("mid_rst.addr", 32'(vm_addr), 32'h0);
        @(negedge clk_50mhz);
        rst = 1'b0;
        @(negedge clk_50mhz);
        expect_out("mid_after1", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk_50mhz);
        expect_out("mid_after2", 1'b0, 12'h0, 8'h0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
